// File: rtl/window_pkg.sv
// Shared constants and FSM state type for the 3x3 RGB window generator.
package window_pkg;

  localparam int IMG_W = 416;
  localparam int PAD_W = IMG_W + 2;
  localparam int PIX_W = 8;

  localparam int ROW_W = PAD_W * PIX_W;
  localparam int WIN_W = 9 * PIX_W;
  localparam int IDX_W = 9;

  typedef enum logic [1:0] {
    FILL,
    SLIDE,
    DONE
  } state_t;

endpackage

// File: rtl/row_tap3.sv
// Picks three adjacent pixels starting at column col out of one padded row.
module row_tap3 #(
  parameter int PAD_W = window_pkg::PAD_W,
  parameter int PIX_W = window_pkg::PIX_W,
  parameter int IDX_W = window_pkg::IDX_W
) (
  input  logic [PAD_W*PIX_W-1:0] row,
  input  logic [IDX_W-1:0]       col,
  output logic [3*PIX_W-1:0]     taps
);

  // Plain column mux; out-of-range columns read as zero.
  always_comb begin
    taps = '0;
    for (int i = 0; i < PAD_W - 2; i++) begin
      if (col == IDX_W'(i)) begin
        taps = row[i*PIX_W +: 3*PIX_W];
      end
    end
  end

endmodule

// File: rtl/window_gen3x3.sv
// Buffers the three newest padded RGB rows and streams 3x3 windows, one
// column per handshake, left to right across each window row.
module window_gen3x3 #(
  parameter int IMG_W = window_pkg::IMG_W,
  parameter int PAD_W = window_pkg::PAD_W,
  parameter int PIX_W = window_pkg::PIX_W
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             row_valid,
  output logic                             row_ready,
  input  logic [PAD_W*PIX_W-1:0]           R_padded,
  input  logic [PAD_W*PIX_W-1:0]           G_padded,
  input  logic [PAD_W*PIX_W-1:0]           B_padded,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [9*PIX_W-1:0]               R_win,
  output logic [9*PIX_W-1:0]               G_win,
  output logic [9*PIX_W-1:0]               B_win,
  output logic [window_pkg::IDX_W-1:0]     win_row,
  output logic [window_pkg::IDX_W-1:0]     win_col,
  output logic                             frame_done
);

  import window_pkg::*;

  localparam int RW = PAD_W * PIX_W;
  localparam int CW = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(IMG_W - 1);
  localparam logic [CW-1:0]    LAST_ROWS = CW'(PAD_W);

  state_t state, state_next;

  logic [2:0][RW-1:0] rows_r, rows_g, rows_b;
  logic [CW-1:0]      rows_in;
  logic [IDX_W-1:0]   col, row_idx;
  logic               accept, win_hs, last_col;

  assign row_ready  = (state == FILL);
  assign win_valid  = (state == SLIDE);
  assign frame_done = (state == DONE);
  assign accept     = row_ready && row_valid;
  assign win_hs     = win_valid && win_ready;
  assign last_col   = (col == LAST_COL);
  assign win_col    = col;
  assign win_row    = row_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_next;
  end

  // rows_in is sampled before its increment, so >= 2 here means the third row.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && rows_in >= CW'(2)) state_next = SLIDE;
      SLIDE:   if (win_hs && last_col) state_next = (rows_in == LAST_ROWS) ? DONE : FILL;
      DONE:    state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_in <= '0;
      col     <= '0;
      row_idx <= '0;
    end else begin
      case (state)
        FILL: if (accept) rows_in <= rows_in + CW'(1);
        SLIDE: begin
          if (win_hs) begin
            if (last_col) begin
              col <= '0;
              if (rows_in != LAST_ROWS) row_idx <= row_idx + IDX_W'(1);
            end else begin
              col <= col + IDX_W'(1);
            end
          end
        end
        DONE: begin
          rows_in <= '0;
          col     <= '0;
          row_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // Index 0 holds the oldest row; a new row enters at index 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_r <= '0;
      rows_g <= '0;
      rows_b <= '0;
    end else if (accept) begin
      rows_r <= {R_padded, rows_r[2], rows_r[1]};
      rows_g <= {G_padded, rows_g[2], rows_g[1]};
      rows_b <= {B_padded, rows_b[2], rows_b[1]};
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_tap
    row_tap3 #(.PAD_W(PAD_W), .PIX_W(PIX_W), .IDX_W(IDX_W)) u_tap_r (
      .row(rows_r[r]), .col(col), .taps(R_win[3*r*PIX_W +: 3*PIX_W])
    );
    row_tap3 #(.PAD_W(PAD_W), .PIX_W(PIX_W), .IDX_W(IDX_W)) u_tap_g (
      .row(rows_g[r]), .col(col), .taps(G_win[3*r*PIX_W +: 3*PIX_W])
    );
    row_tap3 #(.PAD_W(PAD_W), .PIX_W(PIX_W), .IDX_W(IDX_W)) u_tap_b (
      .row(rows_b[r]), .col(col), .taps(B_win[3*r*PIX_W +: 3*PIX_W])
    );
  end

endmodule
